// File: rtl/speriph_port_sched.sv
// Shares one peripheral slave port between NB_REQ requesters.
// Round-robin arbitration with starvation escalation, plus an in-order
// FIFO of issuing requester indices that steers responses back.
module speriph_port_sched #(
    parameter int NB_REQ       = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BE_WIDTH     = 4,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_REQ-1:0]                in_req_i,
    output logic [NB_REQ-1:0]                in_gnt_o,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]     in_add_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]     in_wdata_i,
    input  logic [NB_REQ-1:0]                in_wen_i,
    input  logic [NB_REQ*BE_WIDTH-1:0]       in_be_i,
    output logic [NB_REQ-1:0]                in_r_valid_o,
    output logic [DATA_WIDTH-1:0]            in_r_rdata_o,
    output logic                             in_r_opc_o,
    output logic                             out_req_o,
    input  logic                             out_gnt_i,
    output logic [ADDR_WIDTH-1:0]            out_add_o,
    output logic [DATA_WIDTH-1:0]            out_wdata_o,
    output logic                             out_wen_o,
    output logic [BE_WIDTH-1:0]              out_be_o,
    output logic [NB_REQ-1:0]                out_id_o,
    input  logic                             out_r_valid_i,
    input  logic [DATA_WIDTH-1:0]            out_r_rdata_i,
    input  logic                             out_r_opc_i,
    input  logic [NB_REQ-1:0]                out_r_id_i,
    output logic [$clog2(MAX_OUTST+1)-1:0]   outst_cnt_o,
    output logic                             id_err_o
);

    localparam int IW = $clog2(NB_REQ);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    function automatic logic [NB_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NB_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // Unpacked per-requester views of the flattened request fields
    logic [ADDR_WIDTH-1:0] add_arr   [NB_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NB_REQ];
    logic [BE_WIDTH-1:0]   be_arr    [NB_REQ];

    // State
    logic [CW-1:0]     count_reg, count_next;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [IW-1:0]     rr_ptr_reg;
    logic [IW-1:0]     fifo_mem [MAX_OUTST];
    logic [NB_REQ-1:0] urgent_vec;

    // Combinational control
    logic              any_req;
    logic              full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;
    logic [NB_REQ-1:0] urgent_req;
    logic [NB_REQ-1:0] cand;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     head;

    genvar gi;
    generate
        for (gi = 0; gi < NB_REQ; gi++) begin : g_unpack
            assign add_arr[gi]   = in_add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = in_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign be_arr[gi]    = in_be_i[gi*BE_WIDTH +: BE_WIDTH];
        end
    endgenerate

    assign any_req    = |in_req_i;
    assign full       = (count_reg == CW'(MAX_OUTST));
    assign fifo_empty = (count_reg == '0);
    assign head       = fifo_mem[rd_ptr_reg];

    // Urgent requesters, when any are active, mask out everyone else
    assign urgent_req = urgent_vec & in_req_i;
    assign cand       = (|urgent_req) ? urgent_req : in_req_i;

    // Round-robin pick: first candidate at or after the rr pointer
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NB_REQ) begin
                idx = idx - NB_REQ;
            end
            if (!found && cand[idx]) begin
                winner = idx[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    // Request path: no bypass when full, even if a pop happens this cycle
    assign out_req_o   = any_req & ~full & ~rst_i;
    assign accept      = out_req_o & out_gnt_i;
    assign in_gnt_o    = accept ? onehot(winner) : '0;
    assign out_add_o   = add_arr[winner];
    assign out_wdata_o = wdata_arr[winner];
    assign out_wen_o   = in_wen_i[winner];
    assign out_be_o    = be_arr[winner];
    assign out_id_o    = any_req ? onehot(winner) : '0;

    // Response path: data is routed to the FIFO head even on an id mismatch
    assign pop          = out_r_valid_i & ~fifo_empty & ~rst_i;
    assign in_r_valid_o = pop ? onehot(head) : '0;
    assign in_r_rdata_o = out_r_rdata_i;
    assign in_r_opc_o   = out_r_opc_i;
    assign id_err_o     = out_r_valid_i & ~rst_i &
                          (fifo_empty | (out_r_id_i != onehot(head)));

    assign outst_cnt_o = count_reg;

    // Net change of the in-flight count; accept+pop together leave it as is
    always_comb begin
        count_next = count_reg;
        if (accept && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !accept) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Count, FIFO pointers and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            rr_ptr_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (accept) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                rr_ptr_reg <= (winner == IW'(NB_REQ - 1)) ? '0 : winner + IW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // FIFO storage; validity is tracked by the count, so no reset needed
    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_mem[wr_ptr_reg] <= winner;
        end
    end

    generate
        for (gi = 0; gi < NB_REQ; gi++) begin : g_starve
            logic [SW-1:0] wait_cnt_reg;
            logic          urgent_reg;

            assign urgent_vec[gi] = urgent_reg;

            // Starvation tracking: count ungranted request cycles, flag urgent at the limit
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wait_cnt_reg <= '0;
                    urgent_reg   <= 1'b0;
                end else if (in_gnt_o[gi]) begin
                    wait_cnt_reg <= '0;
                    urgent_reg   <= 1'b0;
                end else if (in_req_i[gi]) begin
                    if (wait_cnt_reg != SW'(STARVE_LIMIT)) begin
                        wait_cnt_reg <= wait_cnt_reg + SW'(1);
                    end
                    if (wait_cnt_reg >= SW'(STARVE_LIMIT - 1)) begin
                        urgent_reg <= 1'b1;
                    end
                end else begin
                    wait_cnt_reg <= '0;
                    urgent_reg   <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_speriph_port_sched.sv
// Self-checking bench for speriph_port_sched: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_speriph_port_sched;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MO = 4;
    localparam int SL = 8;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req;
    logic [AW-1:0]   t_add   [N];
    logic [DW-1:0]   t_wdata [N];
    logic [N-1:0]    t_wen;
    logic [BW-1:0]   t_be    [N];
    logic            ogn;
    logic            rv;
    logic [DW-1:0]   rdata;
    logic            ropc;
    logic [N-1:0]    rid;

    logic [N*AW-1:0] add_flat;
    logic [N*DW-1:0] wdata_flat;
    logic [N*BW-1:0] be_flat;

    logic [N-1:0]    in_gnt, in_r_valid, out_id;
    logic [DW-1:0]   in_r_rdata, out_wdata;
    logic            in_r_opc, out_req, out_wen, id_err;
    logic [AW-1:0]   out_add;
    logic [BW-1:0]   out_be;
    logic [CW-1:0]   outst_cnt;

    always_comb begin
        add_flat   = '0;
        wdata_flat = '0;
        be_flat    = '0;
        for (int i = 0; i < N; i++) begin
            add_flat[i*AW +: AW]   = t_add[i];
            wdata_flat[i*DW +: DW] = t_wdata[i];
            be_flat[i*BW +: BW]    = t_be[i];
        end
    end

    speriph_port_sched #(
        .NB_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW),
        .MAX_OUTST(MO), .STARVE_LIMIT(SL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_req_i     (req),
        .in_gnt_o     (in_gnt),
        .in_add_i     (add_flat),
        .in_wdata_i   (wdata_flat),
        .in_wen_i     (t_wen),
        .in_be_i      (be_flat),
        .in_r_valid_o (in_r_valid),
        .in_r_rdata_o (in_r_rdata),
        .in_r_opc_o   (in_r_opc),
        .out_req_o    (out_req),
        .out_gnt_i    (ogn),
        .out_add_o    (out_add),
        .out_wdata_o  (out_wdata),
        .out_wen_o    (out_wen),
        .out_be_o     (out_be),
        .out_id_o     (out_id),
        .out_r_valid_i(rv),
        .out_r_rdata_i(rdata),
        .out_r_opc_i  (ropc),
        .out_r_id_i   (rid),
        .outst_cnt_o  (outst_cnt),
        .id_err_o     (id_err)
    );

    // Reference model: in-order queue of issuer indices, per-requester
    // starvation counts, next round-robin start position
    int q[$];
    int wait_c[N];
    int rr;
    logic [N-1:0] last_gnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Urgent requesters (waited SL cycles) take precedence; then the
    // first requester scanning upward from rr, wrapping around
    function automatic int model_winner();
        bit urg_any;
        int i;
        urg_any = 1'b0;
        for (int k = 0; k < N; k++)
            if (req[k] && wait_c[k] >= SL) urg_any = 1'b1;
        for (int k = 0; k < N; k++) begin
            i = (rr + k) % N;
            if (req[i] && (!urg_any || wait_c[i] >= SL)) return i;
        end
        return -1;
    endfunction

    // One clock: check outputs against the model, then advance the model
    task automatic cycle();
        int w;
        bit e_oreq, e_err, acc, pp;
        logic [N-1:0] e_gnt, e_rv;
        #1;
        w = model_winner();
        if (rst) begin
            e_oreq = 1'b0;
            e_gnt  = '0;
            e_rv   = '0;
            e_err  = 1'b0;
        end else begin
            e_oreq = (w >= 0) && (q.size() < MO);
            e_gnt  = (e_oreq && ogn) ? oh(w) : '0;
            e_rv   = (rv && q.size() > 0) ? oh(q[0]) : '0;
            e_err  = rv && ((q.size() == 0) || (rid != oh(q[0])));
        end
        check("gnt", 64'(in_gnt), 64'(e_gnt));
        check("out_req", 64'(out_req), 64'(e_oreq));
        check("r_valid", 64'(in_r_valid), 64'(e_rv));
        check("id_err", 64'(id_err), 64'(e_err));
        check("cnt", 64'(outst_cnt), 64'(q.size()));
        if (e_oreq) begin
            check("out_id", 64'(out_id), 64'(oh(w)));
            check("out_add", 64'(out_add), 64'(t_add[w]));
            check("out_wdata", 64'(out_wdata), 64'(t_wdata[w]));
            check("out_wen", 64'(out_wen), 64'(t_wen[w]));
            check("out_be", 64'(out_be), 64'(t_be[w]));
        end
        if (e_rv != '0) begin
            check("rdata", 64'(in_r_rdata), 64'(rdata));
            check("opc", 64'(in_r_opc), 64'(ropc));
        end
        last_gnt = e_gnt;
        acc = (e_gnt != '0);
        pp  = (e_rv != '0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            for (int i = 0; i < N; i++) wait_c[i] = 0;
            rr = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(w);
                rr = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (acc && i == w)   wait_c[i] = 0;
                else if (req[i])     wait_c[i] = (wait_c[i] + 1 > SL) ? SL : wait_c[i] + 1;
                else                 wait_c[i] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; ogn = 1'b0; rv = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int exp_w[5];
        rst = 1'b1; req = '0; ogn = 1'b0; rv = 1'b0; rdata = '0; ropc = 1'b0; rid = '0;
        t_wen = '0;
        for (int i = 0; i < N; i++) begin
            t_add[i] = 32'h1000 * (i + 1); t_wdata[i] = 32'hA0 + i; t_be[i] = 4'hF;
            wait_c[i] = 0;
        end
        rr = 0;
        last_gnt = '0;
        @(negedge clk);
        do_reset();
        check("rst_cnt", 64'(outst_cnt), 64'd0);

        // Single transaction round trip
        req = 4'b0001; ogn = 1'b1;
        #1;
        check("t1_gnt", 64'(in_gnt), 64'h1);
        check("t1_id", 64'(out_id), 64'h1);
        cycle();
        req = '0; ogn = 1'b0;
        check("t1_cnt1", 64'(outst_cnt), 64'd1);
        rv = 1'b1; rid = 4'b0001; rdata = 32'hDEADBEEF; ropc = 1'b0;
        #1;
        check("t1_rv", 64'(in_r_valid), 64'h1);
        cycle();
        rv = 1'b0;
        check("t1_cnt0", 64'(outst_cnt), 64'd0);

        // Rotation with all requesters active and a response each cycle
        do_reset();
        exp_w = '{0, 1, 2, 3, 0};
        req = 4'b1111; ogn = 1'b1;
        for (int j = 0; j < 5; j++) begin
            rv = (q.size() > 0);
            rid = rv ? oh(q[0]) : '0;
            rdata = $urandom;
            #1;
            check("rot_gnt", 64'(in_gnt), 64'(oh(exp_w[j])));
            cycle();
        end
        rv = 1'b0;

        // Fill to the limit, no bypass on the popping cycle
        do_reset();
        req = 4'b0001; ogn = 1'b1;
        for (int j = 0; j < MO; j++) cycle();
        #1;
        check("full_req", 64'(out_req), 64'd0);
        check("full_cnt", 64'(outst_cnt), 64'(MO));
        cycle();
        rv = 1'b1; rid = 4'b0001;
        #1;
        check("full_nobyp", 64'(out_req), 64'd0);
        cycle();
        rv = 1'b0;
        #1;
        check("full_cnt3", 64'(outst_cnt), 64'(MO - 1));
        check("full_req1", 64'(out_req), 64'd1);
        cycle();

        // Starvation escalation
        do_reset();
        req = 4'b0110; ogn = 1'b0;
        for (int j = 0; j < SL; j++) cycle();
        req = 4'b0111; ogn = 1'b1;
        #1; check("urg_g1", 64'(in_gnt), 64'b0010);
        cycle();
        req = 4'b0101;
        #1; check("urg_g2", 64'(in_gnt), 64'b0100);
        cycle();
        req = 4'b0001;
        #1; check("urg_g3", 64'(in_gnt), 64'b0001);
        cycle();
        req = '0;

        // Id mismatch then spurious response
        do_reset();
        req = 4'b0100; ogn = 1'b1;
        cycle();
        req = '0; ogn = 1'b0; rv = 1'b1; rid = 4'b0001;
        #1;
        check("mis_rv", 64'(in_r_valid), 64'b0100);
        check("mis_err", 64'(id_err), 64'd1);
        cycle();
        #1;
        check("spur_rv", 64'(in_r_valid), 64'd0);
        check("spur_err", 64'(id_err), 64'd1);
        cycle();
        rv = 1'b0;

        // Reset with traffic in flight
        do_reset();
        req = 4'b0001; ogn = 1'b1;
        for (int j = 0; j < 3; j++) cycle();
        req = '0;
        check("prerst_cnt", 64'(outst_cnt), 64'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("postrst_cnt", 64'(outst_cnt), 64'd0);
        rv = 1'b1; rid = 4'b0001;
        #1;
        check("stray_rv", 64'(in_r_valid), 64'd0);
        check("stray_err", 64'(id_err), 64'd1);
        cycle();
        rv = 1'b0;

        // Randomized traffic; requesters hold until granted
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i]     = 1'b1;
                    t_add[i]   = $urandom;
                    t_wdata[i] = $urandom;
                    t_wen[i]   = 1'($urandom);
                    t_be[i]    = 4'($urandom);
                end
            end
            rst   = ($urandom % 300 == 0);
            ogn   = ($urandom % 4 != 0);
            rdata = $urandom;
            ropc  = 1'($urandom);
            if (q.size() > 0) rv = ($urandom % 2 == 0);
            else              rv = ($urandom % 40 == 0);
            if (q.size() > 0 && ($urandom % 10 != 0)) rid = oh(q[0]);
            else                                      rid = oh(int'($urandom % N));
            cycle();
            req = req & ~last_gnt;
        end
        rst = 1'b0; rv = 1'b0; req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
